// File: rtl/particle_streamer.sv
// particle_streamer: once per frame, reads every word of the particle buffer in
// address order and streams a 16-bit header plus those words over a quad-SPI
// link (copi/dclk/cs), one nibble per dclk rise, MSB nibble first.
//
// Ports
//   clk_in       system clock
//   rst_n_in     synchronous active-low reset (aborts a frame in progress)
//   frame_start  1-cycle request to begin a frame
//   addr_out     RAM read address (held outside LOAD)
//   mem_enable   RAM port enable, high only in LOAD
//   mem_in       RAM read data, valid READ_LATENCY cycles after addr_out
//   copi         quad data lines, stable across a whole nibble
//   dclk         serial clock, idles low, receiver samples on rise
//   cs           chip select, active-low, idles high
//   busy         frame in progress
//   done         1-cycle pulse in the first idle cycle after a frame
//   overrun      sticky: frame_start seen while busy
//   frame_id     completed frame count, wraps 255 -> 0
module particle_streamer #(
  parameter int unsigned PARTICLE_COUNT = 1,
  parameter int unsigned DIMS           = 1,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = $clog2(PARTICLE_COUNT * DIMS * 2),
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned DCLK_DIV       = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  frame_start,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic [3:0]            copi,
  output logic                  dclk,
  output logic                  cs,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [7:0]            frame_id
);

  localparam int unsigned ELEMENTS = PARTICLE_COUNT * DIMS * 2;
  localparam int unsigned WCNT_W   = $clog2(ELEMENTS + 1);
  localparam int unsigned DIV_W    = $clog2(DCLK_DIV + 1);
  localparam int unsigned LAT_W    = $clog2(READ_LATENCY + 2);

  // Elaboration-time guards on the parameter space this datapath supports.
  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("particle_streamer: DATA_WIDTH must be 16");
  end
  if (DCLK_DIV < 1) begin : g_bad_div
    $error("particle_streamer: DCLK_DIV must be >= 1");
  end
  if (ELEMENTS < 2) begin : g_bad_elems
    $error("particle_streamer: ELEMENTS must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    SHIFT = 3'd2,
    LOAD  = 3'd3,
    TAIL  = 3'd4
  } state_t;

  state_t                  state, state_d;
  logic [DATA_WIDTH-1:0]   shreg, shreg_d;
  logic [DIV_W-1:0]        div_cnt, div_d;
  logic [1:0]              nib_cnt, nib_d;
  logic [LAT_W-1:0]        lat_cnt, lat_d;
  logic [WCNT_W-1:0]       word_cnt, word_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    mem_enable_d;
  logic [3:0]              copi_d;
  logic                    dclk_d;
  logic                    cs_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    overrun_d;
  logic [7:0]              frame_id_d;
  logic                    div_last;

  assign div_last = (div_cnt == DIV_W'(DCLK_DIV - 1));

  // State and output registers; every output is the registered image of its _d.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      shreg      <= '0;
      div_cnt    <= '0;
      nib_cnt    <= '0;
      lat_cnt    <= '0;
      word_cnt   <= '0;
      addr_out   <= '0;
      mem_enable <= 1'b0;
      copi       <= 4'h0;
      dclk       <= 1'b0;
      cs         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      frame_id   <= 8'h00;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      div_cnt    <= div_d;
      nib_cnt    <= nib_d;
      lat_cnt    <= lat_d;
      word_cnt   <= word_d;
      addr_out   <= addr_d;
      mem_enable <= mem_enable_d;
      copi       <= copi_d;
      dclk       <= dclk_d;
      cs         <= cs_d;
      busy       <= busy_d;
      done       <= done_d;
      overrun    <= overrun_d;
      frame_id   <= frame_id_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    div_d      = div_cnt;
    nib_d      = nib_cnt;
    lat_d      = lat_cnt;
    word_d     = word_cnt;
    addr_d     = addr_out;
    dclk_d     = dclk;
    done_d     = 1'b0;
    overrun_d  = overrun;
    frame_id_d = frame_id;

    case (state)
      IDLE: begin
        if (frame_start) begin
          state_d = HDR;
        end
      end

      HDR: begin
        shreg_d  = DATA_WIDTH'({8'hA5, frame_id});
        div_d    = '0;
        nib_d    = '0;
        word_d   = '0;
        dclk_d   = 1'b0;
        state_d  = SHIFT;
      end

      // dclk is its own phase bit: low half, then high half, per nibble.
      SHIFT: begin
        if (div_last) begin
          div_d = '0;
          if (!dclk) begin
            dclk_d = 1'b1;
          end else begin
            dclk_d = 1'b0;
            if (nib_cnt == 2'd3) begin
              nib_d = '0;
              if (word_cnt == WCNT_W'(ELEMENTS)) begin
                state_d = TAIL;
              end else begin
                state_d = LOAD;
                lat_d   = '0;
                addr_d  = word_cnt[ADDR_WIDTH-1:0];
              end
            end else begin
              nib_d   = nib_cnt + 2'd1;
              shreg_d = {shreg[DATA_WIDTH-5:0], 4'h0};
            end
          end
        end else begin
          div_d = div_cnt + DIV_W'(1);
        end
      end

      // Address went out on entry; capture data when it arrives on the last cycle.
      LOAD: begin
        if (lat_cnt == LAT_W'(READ_LATENCY)) begin
          shreg_d = mem_in;
          word_d  = word_cnt + WCNT_W'(1);
          state_d = SHIFT;
        end else begin
          lat_d = lat_cnt + LAT_W'(1);
        end
      end

      TAIL: begin
        if (div_last) begin
          div_d      = '0;
          done_d     = 1'b1;
          frame_id_d = frame_id + 8'd1;
          state_d    = IDLE;
        end else begin
          div_d = div_cnt + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // A request is only honoured in IDLE (including the done cycle).
    if (frame_start && (state != IDLE)) begin
      overrun_d = 1'b1;
    end

    cs_d         = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    mem_enable_d = (state_d == LOAD);
    // copi tracks the top nibble of the register it will shift from next cycle.
    copi_d       = (state_d == SHIFT) ? shreg_d[DATA_WIDTH-1 -: 4] : 4'h0;
  end

endmodule

// File: tb/tb_particle_streamer.sv
// Bench for particle_streamer: two instances (default timing, and DCLK_DIV=1 /
// READ_LATENCY=1) fed by behavioural BRAMs; a link monitor captures nibbles on
// dclk rise and cs-low durations, and frames are compared to a reference built
// from the header/word layout and the cs-low duration formula.
module tb_particle_streamer;

  localparam int E  = 2;
  localparam int NN = 4 + 4 * E;
  localparam int D0 = 2;
  localparam int L0 = 2;
  localparam int D1 = 1;
  localparam int L1 = 1;

  logic clk;
  logic rst_n;
  logic [1:0] fs;

  logic       addr0, addr1;
  logic       me0, me1;
  logic [15:0] mem_in0, mem_in1;
  logic [3:0] copi0, copi1;
  logic       dclk0, dclk1, cs0, cs1, busy0, busy1, done0, done1, ovr0, ovr1;
  logic [7:0] fid0, fid1;

  logic [1:0]       cs_v, dclk_v, busy_v, done_v, ovr_v;
  logic [1:0][3:0]  copi_v;
  logic [1:0][7:0]  fid_v;
  assign cs_v   = {cs1, cs0};
  assign dclk_v = {dclk1, dclk0};
  assign busy_v = {busy1, busy0};
  assign done_v = {done1, done0};
  assign ovr_v  = {ovr1, ovr0};
  assign copi_v = {copi1, copi0};
  assign fid_v  = {fid1, fid0};

  int total = 0;
  int bad   = 0;

  logic [15:0] ram [2][E];
  logic [15:0] p0 [2];
  logic [15:0] p1;
  assign mem_in0 = p0[1];
  assign mem_in1 = p1;

  logic [7:0] exp_fid [2];
  logic       exp_ovr [2];

  int         nib_n [2];
  logic [3:0] nib_buf [2][64];
  logic [3:0] last_nibs [2][64];
  int         last_n [2];
  int         last_len [2];
  int         cs_cnt [2];
  int         hi_run [2];
  logic       prev_cs [2];
  logic       prev_dclk [2];
  logic [3:0] prev_copi [2];

  particle_streamer #(.DCLK_DIV(D0), .READ_LATENCY(L0)) u_dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start(fs[0]),
    .addr_out(addr0), .mem_enable(me0), .mem_in(mem_in0),
    .copi(copi0), .dclk(dclk0), .cs(cs0), .busy(busy0), .done(done0),
    .overrun(ovr0), .frame_id(fid0)
  );

  particle_streamer #(.DCLK_DIV(D1), .READ_LATENCY(L1)) u_dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start(fs[1]),
    .addr_out(addr1), .mem_enable(me1), .mem_in(mem_in1),
    .copi(copi1), .dclk(dclk1), .cs(cs1), .busy(busy1), .done(done1),
    .overrun(ovr1), .frame_id(fid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural BRAMs: registered read plus optional output register.
  initial begin
    forever begin
      @(posedge clk);
      p0[0] <= me0 ? ram[0][addr0] : 16'hDEAD;
      p0[1] <= p0[0];
      p1    <= me1 ? ram[1][addr1] : 16'hBEEF;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  function automatic int dlen(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int exp_len(input int i);
    int d, l;
    d = (i == 0) ? D0 : D1;
    l = (i == 0) ? L0 : L1;
    return 1 + 8 * d + E * (l + 1 + 8 * d) + d;
  endfunction

  // Reference nibble j of a frame: header word then RAM words, MSB nibble first.
  function automatic logic [3:0] exp_nib(input int i, input int j, input logic [7:0] hfid);
    logic [15:0] w;
    int s;
    if (j / 4 == 0) w = 16'hA500 | {8'h00, hfid};
    else            w = ram[i][j / 4 - 1];
    s = 12 - 4 * (j % 4);
    return 4'((w >> s) & 16'h000F);
  endfunction

  // Link monitor: nibbles on dclk rise, cs-low length, dclk high-phase width.
  initial begin
    for (int i = 0; i < 2; i++) begin
      nib_n[i] = 0; cs_cnt[i] = 0; hi_run[i] = 0; last_n[i] = 0; last_len[i] = 0;
      prev_cs[i] = 1'b1; prev_dclk[i] = 1'b0; prev_copi[i] = 4'h0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          nib_n[i] = 0; cs_cnt[i] = 0; hi_run[i] = 0;
          prev_cs[i] = 1'b1; prev_dclk[i] = 1'b0; prev_copi[i] = copi_v[i];
        end else begin
          if (!cs_v[i]) cs_cnt[i]++;
          if (dclk_v[i]) hi_run[i]++;
          if (dclk_v[i] && !prev_dclk[i]) begin
            check($sformatf("i%0d_copi_stable", i), 32'(copi_v[i]), 32'(prev_copi[i]));
            if (nib_n[i] < 64) nib_buf[i][nib_n[i]] = copi_v[i];
            nib_n[i]++;
          end
          if (!dclk_v[i] && prev_dclk[i]) begin
            check($sformatf("i%0d_dclk_high", i), 32'(hi_run[i]), 32'(dlen(i)));
            hi_run[i] = 0;
          end
          if (cs_v[i] && !prev_cs[i]) begin
            last_len[i] = cs_cnt[i];
            last_n[i]   = nib_n[i];
            for (int k = 0; k < 64; k++) last_nibs[i][k] = nib_buf[i][k];
            nib_n[i]  = 0;
            cs_cnt[i] = 0;
          end
          prev_cs[i]   = cs_v[i];
          prev_dclk[i] = dclk_v[i];
          prev_copi[i] = copi_v[i];
        end
      end
    end
  end

  task automatic do_reset;
    fs    = 2'b00;
    rst_n = 1'b0;
    tick;
    tick;
    check("rst_cs",      32'(cs0),   32'd1);
    check("rst_dclk",    32'(dclk0), 32'd0);
    check("rst_copi",    32'(copi0), 32'd0);
    check("rst_addr",    32'(addr0), 32'd0);
    check("rst_me",      32'(me0),   32'd0);
    check("rst_busy",    32'(busy0), 32'd0);
    check("rst_done",    32'(done0), 32'd0);
    check("rst_overrun", 32'(ovr0),  32'd0);
    check("rst_fid",     32'(fid0),  32'd0);
    check("rst_cs1",     32'(cs1),   32'd1);
    check("rst_busy1",   32'(busy1), 32'd0);
    check("rst_fid1",    32'(fid1),  32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_fid[i] = 8'h00;
      exp_ovr[i] = 1'b0;
    end
    tick;
  endtask

  // One frame on instance i; optionally an overlapping request at cycle ovr_at,
  // and optionally a new request in the done cycle (chain).
  task automatic run_frame(input int i, input bit started, input bit rand_ram,
                           input int ovr_at, input bit chain);
    int n;
    bit seen;
    logic [7:0] hfid;
    if (rand_ram) for (int k = 0; k < E; k++) ram[i][k] = 16'($urandom);
    hfid = exp_fid[i];
    if (!started) fs[i] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      tick;
      n++;
      seen  = done_v[i];
      fs[i] = (!seen && ovr_at != 0 && n == ovr_at) || (seen && chain);
    end
    if (!seen) begin
      check($sformatf("i%0d_done_timeout", i), 32'd0, 32'd1);
      fs[i] = 1'b0;
      return;
    end
    if (ovr_at != 0) exp_ovr[i] = 1'b1;
    exp_fid[i] = exp_fid[i] + 8'd1;
    check($sformatf("i%0d_busy_at_done", i), 32'(busy_v[i]), 32'd0);
    check($sformatf("i%0d_cs_at_done", i),   32'(cs_v[i]),   32'd1);
    check($sformatf("i%0d_frame_id", i),     32'(fid_v[i]),  32'(exp_fid[i]));
    check($sformatf("i%0d_overrun", i),      32'(ovr_v[i]),  32'(exp_ovr[i]));
    check($sformatf("i%0d_cs_low_len", i),   32'(last_len[i]), 32'(exp_len(i)));
    check($sformatf("i%0d_nib_count", i),    32'(last_n[i]),   32'(NN));
    for (int j = 0; j < NN; j++)
      check($sformatf("i%0d_nib%0d", i, j), 32'(last_nibs[i][j]), 32'(exp_nib(i, j, hfid)));
    tick;
    fs[i] = 1'b0;
    check($sformatf("i%0d_done_width", i), 32'(done_v[i]), 32'd0);
    check($sformatf("i%0d_busy_after", i), 32'(busy_v[i]), 32'(chain));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    bit ch;
    int ov;
    rst_n = 1'b0;
    fs    = 2'b00;
    ram[0][0] = 16'h1234; ram[0][1] = 16'hABCD;
    ram[1][0] = 16'h1234; ram[1][1] = 16'hABCD;
    tick;
    do_reset;

    // Known data, then an overlapping request, then a back-to-back pair.
    run_frame(0, 1'b0, 1'b0, 0, 1'b0);
    run_frame(0, 1'b0, 1'b0, 10, 1'b0);
    run_frame(0, 1'b0, 1'b1, 0, 1'b1);
    run_frame(0, 1'b1, 1'b0, 0, 1'b0);

    // Random frames with random gaps, overlaps and chaining.
    pend = 1'b0;
    repeat (8) begin
      if (!pend) repeat ($urandom_range(0, 3)) tick;
      ov = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 50)) : 0;
      ch = 1'($urandom_range(0, 1));
      run_frame(0, pend, !pend, ov, ch);
      pend = ch;
    end
    if (pend) run_frame(0, 1'b1, 1'b0, 0, 1'b0);

    // Reset in the middle of a frame.
    fs[0] = 1'b1;
    tick;
    fs[0] = 1'b0;
    repeat ($urandom_range(5, 40)) tick;
    do_reset;

    // Fast instance: known data first, then random.
    run_frame(1, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) begin
      ov = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 20)) : 0;
      run_frame(1, 1'b0, 1'b1, ov, 1'b0);
    end

    // frame_id wrap: 256 frames from reset, then check the next header.
    do_reset;
    repeat (256) run_frame(1, 1'b0, 1'b1, 0, 1'b0);
    check("wrap_fid", 32'(fid1), 32'd0);
    run_frame(1, 1'b0, 1'b1, 0, 1'b0);
    check("wrap_hdr_hi", 32'(last_nibs[1][2]), 32'd0);
    check("wrap_hdr_lo", 32'(last_nibs[1][3]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
